// File: rtl/random_pulse_analyzer.sv
// Purpose : measures high-time and rising-edge period of an asynchronous pulse stream.
// Latency : SYNC_STAGES+1 clk from a pulse_in edge to its detection; a record appears
//           on meas_* one clk after the closing rising edge is detected.
// Backpressure: one-deep holding register; a record produced while the held one is
//           still unaccepted is dropped and the sticky overrun flag is set.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   en                       analyzer enable (low forces IDLE and zeroes the counters)
//   clr                      synchronous clear of pulse_count and overrun
//   pulse_in                 asynchronous pulse input
//   meas_valid / meas_ready  result record handshake
//   meas_width, meas_period  held record: high-time and period in clk cycles
//   pulse_count              8-bit wrapping count of rising edges seen while enabled
//   overrun                  sticky: at least one record was dropped
module random_pulse_analyzer #(
   parameter int CW          = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          en,
   input  logic          clr,
   input  logic          pulse_in,
   output logic          meas_valid,
   input  logic          meas_ready,
   output logic [CW-1:0] meas_width,
   output logic [CW-1:0] meas_period,
   output logic [7:0]    pulse_count,
   output logic          overrun
);

   // Fewer than two flops would not give a usable synchronizer.
   localparam int SS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

   localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};
   localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nxt;

   logic [SS-1:0] sync_q;
   logic          pulse_s;
   logic          pulse_s_d1;
   logic          rise;
   logic          fall;

   logic [CW-1:0] width_cnt;
   logic [CW-1:0] period_cnt;
   logic [CW-1:0] cap_width;

   logic          rec_gen;
   logic          rec_load;
   logic          rec_drop;
   logic          handshake;

   // ------------------------------------------------------------------
   // Input synchronizer and edge detection. The chain keeps running with
   // en low so that re-enabling does not see a stale level as an edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q     <= '0;
         pulse_s_d1 <= 1'b0;
      end else begin
         sync_q     <= {sync_q[SS-2:0], pulse_in};
         pulse_s_d1 <= pulse_s;
      end
   end

   assign pulse_s = sync_q[SS-1];
   assign rise    = pulse_s & ~pulse_s_d1;
   assign fall    = ~pulse_s & pulse_s_d1;

   // ------------------------------------------------------------------
   // Measurement FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      rec_gen   = 1'b0;
      if (!en) begin
         state_nxt = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE: begin
               // First rising edge only arms the period measurement.
               if (rise) state_nxt = ST_HIGH;
            end
            ST_HIGH: begin
               if (fall) state_nxt = ST_LOW;
            end
            ST_LOW: begin
               if (rise) begin
                  state_nxt = ST_HIGH;
                  rec_gen   = 1'b1;
               end
            end
            default: state_nxt = ST_IDLE;
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Width / period counters. A rise restarts both at 1 because the rise
   // cycle itself is the first cycle of the new pulse. Both saturate.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         width_cnt  <= '0;
         period_cnt <= '0;
      end else if (!en) begin
         width_cnt  <= '0;
         period_cnt <= '0;
      end else if (rise) begin
         width_cnt  <= CNT_ONE;
         period_cnt <= CNT_ONE;
      end else begin
         if (state == ST_HIGH && width_cnt != CNT_MAX) begin
            width_cnt <= width_cnt + CNT_ONE;
         end
         if ((state == ST_HIGH || state == ST_LOW) && period_cnt != CNT_MAX) begin
            period_cnt <= period_cnt + CNT_ONE;
         end
      end
   end

   // Width is frozen on the falling edge; the period is only known at the
   // next rise, so the pair is assembled there.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cap_width <= '0;
      end else if (en && state == ST_HIGH && fall) begin
         cap_width <= width_cnt;
      end
   end

   // ------------------------------------------------------------------
   // Output holding register. A handshake in the same cycle as a new
   // record frees the slot, so the new record is taken rather than dropped.
   // ------------------------------------------------------------------
   assign handshake = meas_valid & meas_ready;
   assign rec_load  = rec_gen & (~meas_valid | meas_ready);
   assign rec_drop  = rec_gen & meas_valid & ~meas_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meas_valid  <= 1'b0;
         meas_width  <= '0;
         meas_period <= '0;
      end else if (rec_load) begin
         meas_valid  <= 1'b1;
         meas_width  <= cap_width;
         meas_period <= period_cnt;
      end else if (handshake) begin
         meas_valid  <= 1'b0;
      end
   end

   // A drop in the same cycle as clr still leaves overrun set, so the
   // loss is never hidden.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
      end else if (rec_drop) begin
         overrun <= 1'b1;
      end else if (clr) begin
         overrun <= 1'b0;
      end
   end

   // clr together with a counted rise leaves the count at 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pulse_count <= 8'd0;
      end else if (clr) begin
         pulse_count <= (en && rise) ? 8'd1 : 8'd0;
      end else if (en && rise) begin
         pulse_count <= pulse_count + 8'd1;
      end
   end

endmodule

// File: tb/tb_random_pulse_analyzer.sv
// Purpose : self-checking bench for random_pulse_analyzer (scoreboarded records).
// Latency : records are compared when the DUT hands them over (valid & ready).
// Backpressure: meas_ready is driven by the stimulus to hold, drop and overlap records.
module tb_random_pulse_analyzer;

   localparam int CW = 16;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          clr;
   logic          pulse_in;
   logic          meas_ready;
   logic          meas_valid;
   logic [CW-1:0] meas_width;
   logic [CW-1:0] meas_period;
   logic [7:0]    pulse_count;
   logic          overrun;

   logic          n_valid;
   logic [3:0]    n_width;
   logic [3:0]    n_period;
   logic [7:0]    n_count;
   logic          n_overrun;

   int            total = 0;
   int            bad   = 0;
   int            rec_cnt = 0;
   int            rec_base;
   logic [31:0]   sb_q[$];
   logic [31:0]   mon_exp;

   always #5 clk = ~clk;

   random_pulse_analyzer #(.CW(CW), .SYNC_STAGES(SS)) dut (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .pulse_in(pulse_in),
      .meas_valid(meas_valid), .meas_ready(meas_ready),
      .meas_width(meas_width), .meas_period(meas_period),
      .pulse_count(pulse_count), .overrun(overrun)
   );

   // Narrow instance sharing the same stimulus, used for saturation.
   random_pulse_analyzer #(.CW(4), .SYNC_STAGES(SS)) dut_n (
      .clk(clk), .rst(rst), .en(en), .clr(clr), .pulse_in(pulse_in),
      .meas_valid(n_valid), .meas_ready(meas_ready),
      .meas_width(n_width), .meas_period(n_period),
      .pulse_count(n_count), .overrun(n_overrun)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   // Output monitor: each accepted record is checked against the scoreboard.
   always @(negedge clk) begin
      if (!rst && meas_valid && meas_ready) begin
         rec_cnt++;
         if (sb_q.size() == 0) begin
            chk("rec_unexpected", 32'd1, 32'd0);
         end else begin
            mon_exp = sb_q.pop_front();
            chk("rec_width", 32'(meas_width), 32'(mon_exp[31:16]));
            chk("rec_period", 32'(meas_period), 32'(mon_exp[15:0]));
         end
      end
   end

   task automatic push_rec(input int w, input int p);
      sb_q.push_back({w[15:0], p[15:0]});
   endtask

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic drive_pulse(input int hi, input int lo);
      pulse_in = 1'b1;
      cycles(hi);
      pulse_in = 1'b0;
      cycles(lo);
   endtask

   // One cycle with en low (FSM back to IDLE) and clr high.
   task automatic restart;
      en  = 1'b0;
      clr = 1'b1;
      cycles(1);
      en  = 1'b1;
      clr = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clr = 1'b0; pulse_in = 1'b0; meas_ready = 1'b0;
      #3;
      chk("rst_valid", 32'(meas_valid), 32'd0);
      chk("rst_width", 32'(meas_width), 32'd0);
      chk("rst_period", 32'(meas_period), 32'd0);
      chk("rst_count", 32'(pulse_count), 32'd0);
      chk("rst_overrun", 32'(overrun), 32'd0);
      cycles(3);
      rst = 1'b0;
      cycles(1);

      // Two 3/7 pulses: one record, two edges counted.
      en = 1'b1; meas_ready = 1'b1;
      drive_pulse(3, 7);
      push_rec(3, 10);
      drive_pulse(3, 7);
      cycles(3);
      chk("basic_count", 32'(pulse_count), 32'd2);
      chk("basic_overrun", 32'(overrun), 32'd0);

      // Backpressure: first record held, third rise dropped.
      restart();
      meas_ready = 1'b0;
      drive_pulse(2, 3);
      push_rec(2, 5);
      drive_pulse(2, 3);
      drive_pulse(2, 3);
      cycles(3);
      chk("hold_valid", 32'(meas_valid), 32'd1);
      chk("hold_width", 32'(meas_width), 32'd2);
      chk("hold_period", 32'(meas_period), 32'd5);
      chk("hold_overrun", 32'(overrun), 32'd1);
      chk("hold_count", 32'(pulse_count), 32'd3);
      meas_ready = 1'b1;
      cycles(1);
      meas_ready = 1'b0;
      chk("hold_drained", 32'(meas_valid), 32'd0);

      // Handshake in the very cycle a new record is produced.
      restart();
      drive_pulse(2, 3);
      push_rec(2, 5);
      drive_pulse(4, 4);
      pulse_in = 1'b1;
      cycles(SS);               // now in the cycle where the rise is seen
      meas_ready = 1'b1;
      push_rec(4, 8);
      cycles(1);
      meas_ready = 1'b0;
      chk("ovl_valid", 32'(meas_valid), 32'd1);
      chk("ovl_width", 32'(meas_width), 32'd4);
      chk("ovl_period", 32'(meas_period), 32'd8);
      chk("ovl_overrun", 32'(overrun), 32'd0);
      pulse_in = 1'b0;
      cycles(4);
      meas_ready = 1'b1;
      cycles(2);

      // Reset in the middle of a pulse.
      restart();
      pulse_in = 1'b1;
      cycles(4);
      rst = 1'b1;
      #1;
      chk("mrst_valid", 32'(meas_valid), 32'd0);
      chk("mrst_width", 32'(meas_width), 32'd0);
      chk("mrst_period", 32'(meas_period), 32'd0);
      chk("mrst_count", 32'(pulse_count), 32'd0);
      chk("mrst_overrun", 32'(overrun), 32'd0);
      pulse_in = 1'b0;
      cycles(2);
      rst = 1'b0;
      cycles(1);
      drive_pulse(3, 6);
      push_rec(3, 9);
      drive_pulse(3, 6);
      cycles(3);
      chk("mrst_after_count", 32'(pulse_count), 32'd2);

      // 256 pulses: count wraps to 0, 255 records accepted.
      restart();
      rec_base = rec_cnt;
      for (int i = 0; i < 256; i++) begin
         if (i > 0) push_rec(2, 4);
         drive_pulse(2, 2);
      end
      cycles(4);
      chk("wrap_count", 32'(pulse_count), 32'd0);
      chk("wrap_records", 32'(rec_cnt - rec_base), 32'd255);
      chk("wrap_overrun", 32'(overrun), 32'd0);
      // clr in the same cycle as a counted rise leaves the count at 1.
      pulse_in = 1'b1;
      cycles(SS);
      clr = 1'b1;
      push_rec(2, 8);
      cycles(1);
      clr = 1'b0;
      chk("clr_rise_count", 32'(pulse_count), 32'd1);
      chk("clr_overrun", 32'(overrun), 32'd0);
      pulse_in = 1'b0;
      cycles(4);
      clr = 1'b1;
      cycles(1);
      clr = 1'b0;
      chk("clr_count", 32'(pulse_count), 32'd0);

      // Saturation on the narrow instance: 20 high, 5 low.
      restart();
      drive_pulse(20, 5);
      push_rec(20, 25);
      drive_pulse(2, 3);
      cycles(3);
      chk("sat_width", 32'(n_width), 32'd15);
      chk("sat_period", 32'(n_period), 32'd15);

      // en dropped while a pulse is high: the next rise only arms.
      restart();
      rec_base = rec_cnt;
      pulse_in = 1'b1;
      cycles(5);
      en = 1'b0;
      cycles(1);
      en = 1'b1;
      pulse_in = 1'b0;
      cycles(4);
      drive_pulse(2, 3);
      cycles(3);
      chk("en_fall_records", 32'(rec_cnt - rec_base), 32'd0);
      chk("en_fall_valid", 32'(meas_valid), 32'd0);

      cycles(5);
      chk("sb_empty", 32'(sb_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/random_pulse_analyzer.md
RANDOM_PULSE_ANALYZER -- requirements
Module: random_pulse_analyzer

Interface
REQ-001 The block SHALL have parameter CW, default 16, setting the width of the width/period counters and result fields.
REQ-002 The block SHALL have parameter SYNC_STAGES, default 2, setting the number of input synchronizer flops (min 2).
REQ-003 Port: clk  input  1  sole clock; all state changes on rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-high.
REQ-005 Port: en  input  1  analyzer enable.
REQ-006 Port: clr  input  1  synchronous clear of pulse_count and overrun.
REQ-007 Port: pulse_in  input  1  asynchronous pulse stream from the random pulse generator.
REQ-008 Port: meas_valid  output  1  result record available.
REQ-009 Port: meas_ready  input  1  consumer accepts record.
REQ-010 Port: meas_width  output  CW  high-time of the measured pulse, in clk cycles.
REQ-011 Port: meas_period  output  CW  rising-edge-to-rising-edge interval, in clk cycles.
REQ-012 Port: pulse_count  output  8  number of rising edges detected while enabled.
REQ-013 Port: overrun  output  1  sticky flag: a record was dropped.

Function
REQ-014 pulse_in SHALL pass through SYNC_STAGES flops to give pulse_s; rise = pulse_s & ~pulse_s_d1; fall = ~pulse_s & pulse_s_d1.
REQ-015 FSM states SHALL be IDLE, HIGH, LOW; IDLE -> HIGH on rise; HIGH -> LOW on fall; LOW -> HIGH on rise.
REQ-016 In HIGH, width_cnt SHALL increment each cycle; in HIGH and LOW, period_cnt SHALL increment each cycle; both load 1 on every rise.
REQ-017 Both counters SHALL saturate at 2^CW-1 and never wrap.
REQ-018 On fall in HIGH, width_cnt SHALL be latched into a captured-width register.
REQ-019 On rise in LOW, a record {captured width, period_cnt} SHALL be produced; no record on rise out of IDLE (first pulse only arms).
REQ-020 A produced record SHALL load the output holding register and set meas_valid on the next clock edge.
REQ-021 meas_valid/meas_width/meas_period SHALL remain stable until a cycle with meas_valid & meas_ready.
REQ-022 On handshake with no new record that cycle, meas_valid SHALL drop next cycle.
REQ-023 On handshake coinciding with a new record, the new record SHALL load and meas_valid SHALL stay 1.
REQ-024 If a record is produced while meas_valid=1 and meas_ready=0, the new record SHALL be discarded, held data unchanged, overrun set to 1.
REQ-025 pulse_count SHALL increment on every rise while en=1, wrapping 255 -> 0.
REQ-026 clr SHALL zero pulse_count and overrun next edge; a rise in the same cycle SHALL leave pulse_count = 1; clr SHALL NOT affect meas_valid or FSM.
REQ-027 With en=0 the FSM SHALL go to IDLE and zero both counters; a pending record SHALL stay valid until accepted; synchronizer keeps running.
REQ-028 A pulse still high when en falls SHALL produce no record.

Reset
REQ-029 rst=1 SHALL immediately force FSM=IDLE, synchronizer flops, counters, captured width, meas_width, meas_period, pulse_count to 0, and meas_valid=0, overrun=0.
REQ-030 Reset asserted mid-pulse SHALL discard all partial measurements; after release the next rise only arms (IDLE -> HIGH).

Verification
REQ-031 en=1, pulse_in high 3 cycles then low 7, repeated twice -> one record meas_width=3, meas_period=10; pulse_count=2.
REQ-032 meas_ready=0, three pulses of width 2 period 5 -> first record width=2 period=5 held, overrun=1, pulse_count=3; then meas_ready=1 one cycle -> meas_valid=0.
REQ-033 CW=4, pulse high 20 cycles, low 5, rise -> meas_width=15, meas_period=15.
REQ-034 256 pulses with meas_ready=1 -> pulse_count=0, 255 records accepted, overrun=0; then clr -> pulse_count=0, overrun=0.
REQ-035 rst pulsed while pulse_in high mid-measurement -> all outputs 0 at once; next full pulse pair yields exactly one record with correct width/period.
REQ-036 Record pending, meas_ready=1 in same cycle a new record is produced -> meas_valid stays 1, outputs show new values, overrun=0.
